// File: rtl/hex7seg_scan.sv
// hex7seg_scan: time-multiplexed hex seven-segment scanner with LZB, blanking, dp and dead time.
// Define HEX7SEG_BLINK_EN to add per-digit blinking driven by a frame counter.
module hex7seg_scan #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic [DIGITS-1:0]     blank_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic [DIGITS-1:0]     blink_i,
  input  logic                  lzb_i,
  input  logic                  load_i,
  output logic [0:6]            seg_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     an_o,
  output logic                  frame_o
);
  localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  logic [PW-1:0] p;
  logic [DW-1:0] d, d_nx, sel;
  logic [4*DIGITS-1:0] sh_val;
  logic [DIGITS-1:0] sh_blank, sh_dp, blink_mask;
  logic sh_lzb, last, frame_ev, lz, off;
  logic [3:0] nib;
  logic [0:6] code;
  assign last = p == PW'(SCAN_DIV - 1);
  assign frame_ev = last && d == DW'(DIGITS - 1);
  assign d_nx = d == DW'(DIGITS - 1) ? '0 : d + 1'b1;
  // during the dead cycle the segments already carry the next digit
  assign sel = last ? d_nx : d;
  assign nib = sh_val[{sel, 2'b00} +: 4];
  assign lz = sh_lzb && sel != '0 && (sh_val >> {sel, 2'b00}) == '0;
  assign off = sh_blank[sel] | blink_mask[sel];
  always_comb
    case (nib)
      4'h0: code = 7'b1000000;
      4'h1: code = 7'b1111001;
      4'h2: code = 7'b0100100;
      4'h3: code = 7'b0110000;
      4'h4: code = 7'b0011001;
      4'h5: code = 7'b0010010;
      4'h6: code = 7'b0000010;
      4'h7: code = 7'b1111000;
      4'h8: code = 7'b0000000;
      4'h9: code = 7'b0010000;
      4'hA: code = 7'b0001000;
      4'hB: code = 7'b0000011;
      4'hC: code = 7'b1000110;
      4'hD: code = 7'b0100001;
      4'hE: code = 7'b0000110;
      default: code = 7'b0001110;
    endcase
  always_ff @(posedge clk_i)
    if (rst_i) begin
      p        <= '0;
      d        <= '0;
      sh_val   <= '0;
      sh_blank <= '0;
      sh_dp    <= '0;
      sh_lzb   <= 1'b0;
      seg_o    <= '1;
      dp_o     <= 1'b1;
      an_o     <= '1;
      frame_o  <= 1'b0;
    end else begin
      p <= last ? '0 : p + 1'b1;
      if (last) d <= d_nx;
      if (load_i) begin
        sh_val   <= value_i;
        sh_blank <= blank_i;
        sh_dp    <= dp_i;
        sh_lzb   <= lzb_i;
      end
      seg_o   <= (off | lz) ? 7'b1111111 : code;
      dp_o    <= off | ~sh_dp[sel];
      an_o    <= last ? '1 : ~(DIGITS'(1) << d);
      frame_o <= frame_ev;
    end
`ifdef HEX7SEG_BLINK_EN
  localparam int FW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [DIGITS-1:0] sh_blink;
  logic [FW-1:0] fcnt;
  logic phase;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      sh_blink <= '0;
      fcnt     <= '0;
      phase    <= 1'b0;
    end else begin
      if (load_i) sh_blink <= blink_i;
      if (frame_ev) begin
        fcnt <= fcnt == FW'(BLINK_DIV - 1) ? '0 : fcnt + 1'b1;
        if (fcnt == FW'(BLINK_DIV - 1)) phase <= ~phase;
      end
    end
  assign blink_mask = phase ? sh_blink : '0;
`else
  logic unused_blink;
  assign unused_blink = ^{blink_i, 32'(BLINK_DIV)};
  assign blink_mask = '0;
`endif
endmodule

// File: tb/tb_hex7seg_scan.sv
// tb_hex7seg_scan: scoreboard bench for hex7seg_scan (DIGITS=4, SCAN_DIV=4, BLINK_DIV=2).
module tb_hex7seg_scan;
  localparam logic [6:0] C0 = 7'b1000000, C1 = 7'b1111001, C2 = 7'b0100100, C3 = 7'b0110000;
  localparam logic [6:0] C4 = 7'b0011001, C7 = 7'b1111000, C8 = 7'b0000000, CA = 7'b0001000;
  localparam logic [6:0] CF = 7'b0001110, BL = 7'b1111111;
  typedef struct {
    string      name;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fr;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, lzb = 1'b0, load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0] blank = '0, dpi = '0, blink = '0;
  logic [0:6] seg;
  logic dp, frame;
  logic [3:0] an;
  exp_t sb[$];
  int vectors = 0, misses = 0;
  hex7seg_scan #(.DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2)) dut (
    .clk_i(clk), .rst_i(rst), .value_i(value), .blank_i(blank), .dp_i(dpi),
    .blink_i(blink), .lzb_i(lzb), .load_i(load), .seg_o(seg), .dp_o(dp),
    .an_o(an), .frame_o(frame)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (an !== e.an || seg !== e.seg || dp !== e.dp || frame !== e.fr) begin
        misses++;
        $display("FAIL %s: got an=%b seg=%b dp=%b frame=%b, want an=%b seg=%b dp=%b frame=%b",
                 e.name, an, seg, dp, frame, e.an, e.seg, e.dp, e.fr);
      end
    end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input string nm, input logic [3:0] a, input logic [6:0] s, input logic d, input logic f);
    exp_t e;
    e.name = nm; e.an = a; e.seg = s; e.dp = d; e.fr = f;
    sb.push_back(e);
  endtask
  task automatic push_range(input string nm, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpn,
                            input int lo, input int hi);
    logic [6:0] s[4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int n = lo; n < hi; n++) begin
      int k;
      k = n / 4;
      if (n % 4 < 3) push(nm, ~(4'b0001 << k), s[k], dpn[k], 1'b0);
      else push(nm, 4'b1111, s[(k + 1) % 4], dpn[(k + 1) % 4], k == 3);
    end
  endtask
  task automatic check_frame(input string nm, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpn);
    push_range(nm, s0, s1, s2, s3, dpn, 0, 16);
    repeat (16) tick;
  endtask
  task automatic load_frame(input logic [15:0] v, input logic [3:0] b, input logic [3:0] d,
                            input logic [3:0] bl, input logic lz);
    value = v; blank = b; dpi = d; blink = bl; lzb = lz; load = 1'b1;
    tick;
    load = 1'b0;
    repeat (15) tick;
  endtask
  initial begin
    tick;
    repeat (3) push("reset", 4'b1111, BL, 1'b1, 1'b0);
    push_range("post_reset", C0, C0, C0, C0, 4'hF, 0, 16);
    tick;
    tick;
    rst = 1'b0;
    repeat (17) tick;
    load_frame(16'h8F30, 4'b0000, 4'b0100, 4'b0000, 1'b0);
    check_frame("decode_8F30", C0, C3, CF, C8, 4'b1011);
    load_frame(16'h0007, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    check_frame("lzb_0007", C7, BL, BL, BL, 4'hF);
    load_frame(16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    check_frame("lzb_0000", C0, BL, BL, BL, 4'hF);
    load_frame(16'h0700, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    check_frame("lzb_0700", C0, C0, C7, BL, 4'hF);
    load_frame(16'h1234, 4'b0010, 4'b0010, 4'b0000, 1'b0);
    check_frame("blank_d1", C4, BL, C2, C1, 4'hF);
    push_range("load_mid_old", C4, BL, C2, C1, 4'hF, 0, 10);
    push_range("load_mid_new", C4, BL, CA, C1, 4'hF, 10, 16);
    repeat (8) tick;
    value = 16'h1A34;
    load = 1'b1;
    tick;
    load = 1'b0;
    repeat (7) tick;
    push_range("pre_rst", C4, BL, CA, C1, 4'hF, 0, 9);
    push("rst_mid", 4'b1111, BL, 1'b1, 1'b0);
    push_range("after_rst", C0, C0, C0, C0, 4'hF, 0, 16);
    repeat (8) tick;
    rst = 1'b1;
    value = 16'hFFFF;
    load = 1'b1;
    tick;
    rst = 1'b0;
    load = 1'b0;
    repeat (17) tick;
    load_frame(16'h0001, 4'b0000, 4'b0001, 4'b0001, 1'b0);
`ifdef HEX7SEG_BLINK_EN
    check_frame("blink_off1", BL, C0, C0, C0, 4'hF);
    check_frame("blink_off2", BL, C0, C0, C0, 4'hF);
`else
    check_frame("noblink1", C1, C0, C0, C0, 4'b1110);
    check_frame("noblink2", C1, C0, C0, C0, 4'b1110);
`endif
    check_frame("blink_on1", C1, C0, C0, C0, 4'b1110);
    check_frame("blink_on2", C1, C0, C0, C0, 4'b1110);
    if (sb.size() != 0) begin
      misses++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule
